// File: rtl/fib_sequencer.sv
// Fibonacci-style sequence engine: two operand registers, sum written over the older one,
// terms streamed on a valid/ready port, stop on value limit, term count or carry-out.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; outputs from last run held
// S_ADD   | sum the operand registers into term, detect carry-out
// S_EMIT  | term_valid high until the consumer accepts the term
// S_CHECK | compare term (mode 0) or count (mode 1) against the limit
// S_DONE  | one-cycle done pulse, then back to idle
module fib_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] term,
  output logic             term_valid,
  input  logic             term_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_EMIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] lim_q;
  logic             mode_q;
  logic             ptr;
  logic [WIDTH:0]   sum;
  logic [CNT_W-1:0] lim_cnt;
  logic [CNT_W-1:0] limit_cnt;
  logic [CNT_W-1:0] cnt_one;

  logic             load;
  logic             add_en;
  logic             accept;

  // In count mode the limit is read as a CNT_W-bit quantity, whichever width is wider.
  generate
    if (CNT_W <= WIDTH) begin : g_lim_trunc
      assign lim_cnt   = lim_q[CNT_W-1:0];
      assign limit_cnt = limit[CNT_W-1:0];
    end else begin : g_lim_ext
      assign lim_cnt   = {{(CNT_W-WIDTH){1'b0}}, lim_q};
      assign limit_cnt = {{(CNT_W-WIDTH){1'b0}}, limit};
    end
  endgenerate

  assign sum     = {1'b0, ra} + {1'b0, rb};
  assign cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    add_en     = 1'b0;
    accept     = 1'b0;
    term_valid = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load      = 1'b1;
          state_nxt = (mode && (limit_cnt == '0)) ? S_DONE : S_ADD;
        end
      end
      S_ADD: begin
        add_en    = 1'b1;
        state_nxt = sum[WIDTH] ? S_DONE : S_EMIT;
      end
      S_EMIT: begin
        term_valid = 1'b1;
        if (term_ready) begin
          accept    = 1'b1;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mode_q) begin
          state_nxt = (count == lim_cnt) ? S_DONE : S_ADD;
        end else begin
          state_nxt = (term > lim_q) ? S_DONE : S_ADD;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort masks every strobe so nothing is loaded, emitted or reported this cycle.
    if (clr) begin
      state_nxt  = S_IDLE;
      load       = 1'b0;
      add_en     = 1'b0;
      accept     = 1'b0;
      term_valid = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra       <= '0;
      rb       <= '0;
      lim_q    <= '0;
      mode_q   <= 1'b0;
      ptr      <= 1'b0;
      term     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        ra       <= seed_a;
        rb       <= seed_b;
        lim_q    <= limit;
        mode_q   <= mode;
        ptr      <= 1'b0;
        count    <= '0;
        overflow <= 1'b0;
      end
      if (add_en) begin
        term <= sum[WIDTH-1:0];
        if (sum[WIDTH]) begin
          overflow <= 1'b1;
        end
      end
      // ptr names the register holding the older term, which the new term replaces.
      if (accept) begin
        if (ptr) begin
          rb <= term;
        end else begin
          ra <= term;
        end
        ptr   <= ~ptr;
        count <= count + cnt_one;
      end
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Bench for fib_sequencer: directed cases plus randomized runs checked against a
// plain-arithmetic model of the sequence and its stop rules.
module tb_fib_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clr;
  logic       mode;
  logic [7:0] seed_a;
  logic [7:0] seed_b;
  logic [7:0] limit;
  logic [7:0] term;
  logic       term_valid;
  logic       term_ready;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         exp_cnt;
  logic       exp_ovf;
  int         done_cnt;
  int         first_valid;
  int         stable_bad;
  int         gaps_bad;
  bit         timed_out;

  fib_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clr        (clr),
    .mode       (mode),
    .seed_a     (seed_a),
    .seed_b     (seed_b),
    .limit      (limit),
    .term       (term),
    .term_valid (term_valid),
    .term_ready (term_ready),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Sequence model: the next term is the sum of the last two; stop rules applied in order.
  task automatic model(input int sa, input int sb, input int lim, input int md);
    int a, b, s, n;
    exp_q.delete();
    exp_ovf = 1'b0;
    n = 0;
    a = sa;
    b = sb;
    if (!(md == 1 && lim == 0)) begin
      while (n < 300) begin
        s = a + b;
        if (s > 255) begin
          exp_ovf = 1'b1;
          break;
        end
        exp_q.push_back(8'(s));
        n++;
        a = b;
        b = s;
        if (md == 0 && s > lim) break;
        if (md == 1 && n == lim) break;
      end
    end
    exp_cnt = n;
  endtask

  // Drives one run and records accepted terms and timing; the calling test does the checking.
  task automatic run_seq(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] lim,
                         input logic md, input int rdy_pct, input bit poke_start);
    int cyc, last_acc;
    bit fin, stalled;
    logic [7:0] held;
    got_q.delete();
    done_cnt = 0; first_valid = -1; stable_bad = 0; gaps_bad = 0; timed_out = 0;
    last_acc = -1; fin = 0; stalled = 0; held = '0;
    @(negedge clk);
    seed_a = sa; seed_b = sb; limit = lim; mode = md; start = 1'b1;
    term_ready = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      term_ready = ($urandom_range(99) < rdy_pct);
      if (term_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (stalled && term !== held) stable_bad++;
        if (term_ready) begin
          got_q.push_back(term);
          if (last_acc >= 0 && cyc - last_acc != 3) gaps_bad++;
          last_acc = cyc;
          stalled = 0;
        end else begin
          stalled = 1;
          held = term;
        end
      end
      if (done) begin
        done_cnt++;
        fin = 1;
      end
      if (poke_start && !fin) begin
        start  = $urandom_range(1);
        seed_a = 8'($urandom_range(255));
        seed_b = 8'($urandom_range(255));
        limit  = 8'($urandom_range(255));
        mode   = $urandom_range(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (done) done_cnt++;
    timed_out = !fin;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; clr = 1'b0; mode = 1'b0; term_ready = 1'b0;
    seed_a = '0; seed_b = '0; limit = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (term !== 8'd0) begin errors++; $display("FAIL reset_term got %0d exp 0", term); end
    checks++; if (term_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", term_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
  endtask

  task automatic test_directed();
    int sa [4] = '{1, 0, 1, 5};
    int sb [4] = '{1, 1, 1, 7};
    int lm [4] = '{20, 4, 255, 0};
    int md [4] = '{0, 1, 0, 1};
    int ec [4] = '{6, 4, 11, 0};
    for (int t = 0; t < 4; t++) begin
      model(sa[t], sb[t], lm[t], md[t]);
      run_seq(8'(sa[t]), 8'(sb[t]), 8'(lm[t]), md[t][0], 100, 0);
      checks++; if (timed_out) begin errors++; $display("FAIL dir%0d timeout got no done exp done", t); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL dir%0d nterms got %0d exp %0d", t, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL dir%0d term[%0d] got %0d exp %0d", t, i, got_q[i], exp_q[i]); end
      end
      checks++; if (count !== 8'(ec[t])) begin errors++; $display("FAIL dir%0d count got %0d exp %0d", t, count, ec[t]); end
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL dir%0d overflow got %b exp %b", t, overflow, exp_ovf); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL dir%0d done_pulses got %0d exp 1", t, done_cnt); end
      checks++; if (first_valid != (exp_q.size() > 0 ? 2 : -1)) begin errors++; $display("FAIL dir%0d first_valid got %0d exp %0d", t, first_valid, exp_q.size() > 0 ? 2 : -1); end
      checks++; if (gaps_bad != 0) begin errors++; $display("FAIL dir%0d term_spacing got %0d bad gaps exp 0", t, gaps_bad); end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int k;
    @(negedge clk);
    seed_a = 8'd1; seed_b = 8'd1; limit = 8'd20; mode = 1'b0; term_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (k = 0; k < 20 && !seen; k++) begin
      if (term_valid) seen = 1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_valid got 0 exp 1"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (term_valid !== 1'b1 || term !== 8'd2 || count !== 8'd0) begin
        errors++; $display("FAIL bp_stall%0d got v=%b t=%0d c=%0d exp v=1 t=2 c=0", i, term_valid, term, count);
      end
      @(negedge clk);
    end
    term_ready = 1'b1;
    @(negedge clk);
    checks++; if (count !== 8'd1 || term_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got c=%0d v=%b exp c=1 v=0", count, term_valid); end
    seen = 0;
    for (k = 0; k < 60 && !seen; k++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    checks++; if (!seen || count !== 8'd6) begin errors++; $display("FAIL bp_end got done=%b c=%0d exp done=1 c=6", seen, count); end
    @(negedge clk);
  endtask

  task automatic test_clr();
    int nv, dcnt;
    bit hit;
    @(negedge clk);
    seed_a = 8'd1; seed_b = 8'd1; limit = 8'd100; mode = 1'b0; term_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nv = 0; hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (term_valid) begin
        nv++;
        if (nv == 3) begin
          term_ready = 1'b0; clr = 1'b1; hit = 1;
        end
      end
      if (!hit) @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL clr_reach3 got %0d terms exp 3", nv); end
    @(negedge clk);
    clr = 1'b0; term_ready = 1'b1;
    checks++; if (busy !== 1'b0 || term_valid !== 1'b0) begin errors++; $display("FAIL clr_idle got busy=%b v=%b exp 0 0", busy, term_valid); end
    checks++; if (count !== 8'd2) begin errors++; $display("FAIL clr_count got %0d exp 2", count); end
    dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL clr_nodone got %0d exp 0", dcnt); end
    start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    checks++; if (busy !== 1'b0 || count !== 8'd2) begin errors++; $display("FAIL clr_start got busy=%b c=%0d exp 0 2", busy, count); end
    model(3, 4, 60, 0);
    run_seq(8'd3, 8'd4, 8'd60, 1'b0, 100, 0);
    checks++; if (timed_out || got_q.size() != exp_q.size()) begin errors++; $display("FAIL clr_rerun nterms got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL clr_rerun term[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (count !== 8'(exp_cnt)) begin errors++; $display("FAIL clr_rerun count got %0d exp %0d", count, exp_cnt); end
  endtask

  task automatic test_rst_mid();
    int acc;
    bit hit;
    @(negedge clk);
    seed_a = 8'd1; seed_b = 8'd1; limit = 8'd200; mode = 1'b0; term_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0; hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (term_valid && term_ready) acc++;
      if (acc == 2) hit = 1;
      @(negedge clk);
    end
    @(negedge clk);
    checks++; if (!hit || busy !== 1'b1 || count !== 8'd2 || term !== 8'd3) begin
      errors++; $display("FAIL rst_pre got busy=%b c=%0d t=%0d exp 1 2 3", busy, count, term);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (term !== 8'd0 || count !== 8'd0 || term_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rst_mid got t=%0d c=%0d v=%b b=%b d=%b o=%b exp all 0", term, count, term_valid, busy, done, overflow);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    model(1, 2, 100, 0);
    run_seq(8'd1, 8'd2, 8'd100, 1'b0, 60, 1);
    checks++; if (timed_out || got_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_start nterms got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_start term[%0d] got %0d exp %0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (count !== 8'(exp_cnt)) begin errors++; $display("FAIL busy_start count got %0d exp %0d", count, exp_cnt); end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL busy_start stall_stable got %0d exp 0", stable_bad); end
  endtask

  task automatic test_random();
    int sa, sb, lm, md, rp;
    for (int r = 0; r < 25; r++) begin
      sa = $urandom_range(255);
      sb = $urandom_range(255);
      md = $urandom_range(1);
      if (md == 1) lm = ($urandom_range(9) == 0) ? 0 : $urandom_range(30, 1);
      else lm = $urandom_range(255);
      if (sa == 0 && sb == 0) sb = 1;
      rp = $urandom_range(100, 30);
      model(sa, sb, lm, md);
      run_seq(8'(sa), 8'(sb), 8'(lm), md[0], rp, 0);
      checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d timeout got no done exp done", r); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d nterms got %0d exp %0d", r, got_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < got_q.size()) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d term[%0d] got %0d exp %0d", r, i, got_q[i], exp_q[i]); end
      end
      checks++; if (count !== 8'(exp_cnt)) begin errors++; $display("FAIL rnd%0d count got %0d exp %0d", r, count, exp_cnt); end
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rnd%0d overflow got %b exp %b", r, overflow, exp_ovf); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d done_pulses got %0d exp 1", r, done_cnt); end
      checks++; if (stable_bad != 0) begin errors++; $display("FAIL rnd%0d stall_stable got %0d exp 0", r, stable_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_clr();
    test_rst_mid();
    test_start_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
